// File: rtl/pc_fetch_unit_if.sv
// rtl/pc_fetch_unit_if.sv - instruction-fetch request/response bus between IF and the shared SRAM
interface pc_fetch_unit_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              ibus_req_o;
    logic [ADDR_W-1:0] ibus_addr_o;
    logic              ibus_ack_i;
    logic [DATA_W-1:0] ibus_rdata_i;

    modport master (
        output ibus_req_o,
        output ibus_addr_o,
        input  ibus_ack_i,
        input  ibus_rdata_i
    );

    modport slave (
        input  ibus_req_o,
        input  ibus_addr_o,
        output ibus_ack_i,
        output ibus_rdata_i
    );
endinterface

// File: rtl/pc_fetch_unit.sv
// rtl/pc_fetch_unit.sv - PC register and single-outstanding instruction fetch front end
module pc_fetch_unit #(
    parameter int                ADDR_W     = 32,
    parameter logic [ADDR_W-1:0] RESET_PC   = '0,
    parameter int                INST_BYTES = 4,
    parameter int                DATA_W     = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [5:0]          stall,
    input  logic                flush_i,
    input  logic [ADDR_W-1:0]   flush_target_i,
    input  logic                branch_flag_i,
    input  logic [ADDR_W-1:0]   branch_target_address_i,
    input  logic                mem_busy_i,
    pc_fetch_unit_if.master     ibus,
    output logic [DATA_W-1:0]   inst_o,
    output logic [ADDR_W-1:0]   inst_pc_o,
    output logic                inst_valid_o,
    output logic                misalign_o,
    output logic                stallreq
);

    localparam logic [ADDR_W-1:0] LOW_MASK = ADDR_W'(INST_BYTES - 1);
    localparam logic [ADDR_W-1:0] PC_INC   = ADDR_W'(INST_BYTES);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   pc_q, pc_d;
    logic [ADDR_W-1:0]   req_addr_q, req_addr_d;
    logic                pend_q, pend_d;
    logic                pend_flush_q, pend_flush_d;
    logic [ADDR_W-1:0]   pend_target_q, pend_target_d;
    logic [DATA_W-1:0]   inst_q, inst_d;
    logic [ADDR_W-1:0]   inst_pc_q, inst_pc_d;
    logic                inst_valid_q, inst_valid_d;
    logic                misalign_q, misalign_d;

    logic                redirect;
    logic [ADDR_W-1:0]   raw_target;
    logic [ADDR_W-1:0]   target;
    logic                consume;
    logic                req;
    logic [ADDR_W-1:0]   addr;
    logic                accept;
    logic                unused_stall;

    assign unused_stall = ^stall[5:1];

    always_comb begin
        redirect      = flush_i | branch_flag_i;
        raw_target    = flush_i ? flush_target_i : branch_target_address_i;
        target        = raw_target & ~LOW_MASK;
        consume       = inst_valid_q & ~stall[0];

        state_d       = state_q;
        pc_d          = pc_q;
        req_addr_d    = req_addr_q;
        pend_d        = pend_q;
        pend_flush_d  = pend_flush_q;
        pend_target_d = pend_target_q;
        inst_d        = inst_q;
        inst_pc_d     = inst_pc_q;
        inst_valid_d  = inst_valid_q & stall[0];
        misalign_d    = redirect & (|(raw_target & LOW_MASK));
        req           = 1'b0;
        addr          = '0;
        accept        = 1'b0;

        // Any redirect kills a held instruction that IF/ID has not taken yet.
        if (redirect) begin
            inst_valid_d = 1'b0;
        end

        case (state_q)
            IDLE: begin
                if (redirect) begin
                    pc_d = target;
                end else if (!mem_busy_i && (!inst_valid_q || consume)) begin
                    req        = 1'b1;
                    addr       = pc_q;
                    req_addr_d = pc_q;
                    state_d    = BUSY;
                end
            end
            BUSY: begin
                req  = 1'b1;
                addr = req_addr_q;
                // A stored flush is only displaced by another flush, never by a branch.
                if (redirect && (!pend_q || flush_i || !pend_flush_q)) begin
                    pend_d        = 1'b1;
                    pend_flush_d  = flush_i;
                    pend_target_d = target;
                end
                if (ibus.ibus_ack_i) begin
                    state_d      = IDLE;
                    pend_d       = 1'b0;
                    pend_flush_d = 1'b0;
                    if (pend_q || redirect) begin
                        pc_d = pend_target_d;
                    end else begin
                        accept       = 1'b1;
                        inst_d       = ibus.ibus_rdata_i;
                        inst_pc_d    = req_addr_q;
                        inst_valid_d = 1'b1;
                        pc_d         = req_addr_q + PC_INC;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            pc_q          <= RESET_PC;
            req_addr_q    <= '0;
            pend_q        <= 1'b0;
            pend_flush_q  <= 1'b0;
            pend_target_q <= '0;
            inst_q        <= '0;
            inst_pc_q     <= '0;
            inst_valid_q  <= 1'b0;
            misalign_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            req_addr_q    <= req_addr_d;
            pend_q        <= pend_d;
            pend_flush_q  <= pend_flush_d;
            pend_target_q <= pend_target_d;
            inst_q        <= inst_d;
            inst_pc_q     <= inst_pc_d;
            inst_valid_q  <= inst_valid_d;
            misalign_q    <= misalign_d;
        end
    end

    // Combinational outputs are forced quiet while reset is held.
    assign ibus.ibus_req_o  = req & ~rst;
    assign ibus.ibus_addr_o = rst ? '0 : addr;
    assign inst_o           = inst_q;
    assign inst_pc_o        = inst_pc_q;
    assign inst_valid_o     = inst_valid_q;
    assign misalign_o       = misalign_q;
    assign stallreq         = ~rst & ~inst_valid_q & ~accept;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// tb/tb_pc_fetch_unit.sv - self-checking bench for pc_fetch_unit with fetch/instruction scoreboards
module tb_pc_fetch_unit;
    localparam int AW = 32;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic [5:0]    stall;
    logic          flush_i;
    logic [AW-1:0] flush_target_i;
    logic          branch_flag_i;
    logic [AW-1:0] branch_target_address_i;
    logic          mem_busy_i;
    logic [DW-1:0] inst_o;
    logic [AW-1:0] inst_pc_o;
    logic          inst_valid_o;
    logic          misalign_o;
    logic          stallreq;

    always #5 clk = ~clk;

    pc_fetch_unit_if #(.ADDR_W(AW), .DATA_W(DW)) ibus ();

    pc_fetch_unit #(.ADDR_W(AW), .RESET_PC(32'h0), .INST_BYTES(4), .DATA_W(DW)) dut (
        .clk                     (clk),
        .rst                     (rst),
        .stall                   (stall),
        .flush_i                 (flush_i),
        .flush_target_i          (flush_target_i),
        .branch_flag_i           (branch_flag_i),
        .branch_target_address_i (branch_target_address_i),
        .mem_busy_i              (mem_busy_i),
        .ibus                    (ibus.master),
        .inst_o                  (inst_o),
        .inst_pc_o               (inst_pc_o),
        .inst_valid_o            (inst_valid_o),
        .misalign_o              (misalign_o),
        .stallreq                (stallreq)
    );

    typedef struct {
        logic [AW-1:0] pc;
        logic [DW-1:0] data;
    } inst_t;

    typedef struct {
        logic          f;
        logic [AW-1:0] ft;
        logic          b;
        logic [AW-1:0] bt;
        logic [AW-1:0] exp_addr;
        logic          exp_mis;
    } vec_t;

    int            n_checks = 0;
    int            n_fail   = 0;
    logic [AW-1:0] exp_fetch_q[$];
    inst_t         exp_inst_q[$];
    bit            busy_b, drop, cap_pending, inv_pending;
    int            wcnt, lat;
    logic [AW-1:0] cur_addr;

    function automatic logic [DW-1:0] word_of(input logic [AW-1:0] a);
        return a ^ 32'h1357_9BDF;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic clear_sb();
        exp_fetch_q.delete();
        exp_inst_q.delete();
        busy_b = 0; drop = 0; cap_pending = 0; inv_pending = 0; wcnt = 0; lat = 0;
        ibus.ibus_ack_i   = 1'b0;
        ibus.ibus_rdata_i = '0;
    endtask

    task automatic chk_reset_outs(input string tag);
        chk({tag, "_req"},      ibus.ibus_req_o, 0);
        chk({tag, "_addr"},     ibus.ibus_addr_o, 0);
        chk({tag, "_inst"},     inst_o, 0);
        chk({tag, "_inst_pc"},  inst_pc_o, 0);
        chk({tag, "_valid"},    inst_valid_o, 0);
        chk({tag, "_misalign"}, misalign_o, 0);
        chk({tag, "_stallreq"}, stallreq, 0);
    endtask

    task automatic do_reset();
        rst = 1'b1; stall = '0; flush_i = 0; flush_target_i = '0;
        branch_flag_i = 0; branch_target_address_i = '0; mem_busy_i = 0;
        clear_sb();
        @(posedge clk); #1;
        chk_reset_outs("reset");
        rst = 1'b0;
    endtask

    // Evaluate the current cycle as the bus slave, then advance past the next edge.
    task automatic tick();
        inst_t e;
        #1;
        if (busy_b) begin
            chk("req_held", ibus.ibus_req_o, 1);
            chk("addr_held", ibus.ibus_addr_o, cur_addr);
            if (flush_i || branch_flag_i) drop = 1;
            if (wcnt >= lat) begin
                ibus.ibus_ack_i   = 1'b1;
                ibus.ibus_rdata_i = word_of(cur_addr);
                busy_b = 0;
                if (drop) inv_pending = 1;
                else begin
                    exp_inst_q.push_back('{cur_addr, word_of(cur_addr)});
                    cap_pending = 1;
                end
                #1;
                chk("stallreq_on_ack", stallreq, drop);
            end else begin
                wcnt++;
            end
        end else if (ibus.ibus_req_o) begin
            busy_b = 1; wcnt = 0; drop = 0;
            cur_addr = ibus.ibus_addr_o;
            if (exp_fetch_q.size() != 0) chk("fetch_addr", ibus.ibus_addr_o, exp_fetch_q.pop_front());
        end
        @(posedge clk); #1;
        ibus.ibus_ack_i = 1'b0;
        if (cap_pending) begin
            cap_pending = 0;
            if (exp_inst_q.size() == 0) chk("inst_sb_empty", 1, 0);
            else begin
                e = exp_inst_q.pop_front();
                chk("inst_valid", inst_valid_o, 1);
                chk("inst_data", inst_o, e.data);
                chk("inst_pc", inst_pc_o, e.pc);
            end
        end
        if (inv_pending) begin
            inv_pending = 0;
            chk("inst_dropped", inst_valid_o, 0);
        end
    endtask

    vec_t vecs[5];

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{1'b1, 32'h0000_0200, 1'b1, 32'h0000_0100, 32'h0000_0200, 1'b0};
        vecs[1] = '{1'b0, 32'h0000_0000, 1'b1, 32'h0000_0103, 32'h0000_0100, 1'b1};
        vecs[2] = '{1'b1, 32'h0000_0302, 1'b0, 32'h0000_0000, 32'h0000_0300, 1'b1};
        vecs[3] = '{1'b0, 32'h0000_0000, 1'b1, 32'h0000_0040, 32'h0000_0040, 1'b0};
        vecs[4] = '{1'b1, 32'hFFFF_FFFC, 1'b1, 32'h0000_0008, 32'hFFFF_FFFC, 1'b0};

        // Sequential fetch with single-cycle ack.
        do_reset();
        exp_fetch_q.push_back(32'h0);
        exp_fetch_q.push_back(32'h4);
        exp_fetch_q.push_back(32'h8);
        repeat (6) tick();

        // MEM owns the bus for three cycles.
        do_reset();
        mem_busy_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("membusy_no_req", ibus.ibus_req_o, 0);
            chk("membusy_stallreq", stallreq, 1);
            tick();
        end
        mem_busy_i = 1'b0;
        exp_fetch_q.push_back(32'h0);
        tick();
        tick();

        // Branch during an in-flight fetch at 0x8, ack arrives later.
        do_reset();
        exp_fetch_q.push_back(32'h0);
        exp_fetch_q.push_back(32'h4);
        exp_fetch_q.push_back(32'h8);
        repeat (4) tick();
        lat = 2;
        tick();
        branch_flag_i = 1'b1; branch_target_address_i = 32'h100;
        tick();
        branch_flag_i = 1'b0;
        tick();
        tick();
        lat = 0;
        exp_fetch_q.push_back(32'h100);
        tick();
        chk("branch_refetch_started", busy_b, 1);

        // Redirect table applied in IDLE: priority, alignment, misalign pulse, PC wrap.
        foreach (vecs[i]) begin
            do_reset();
            flush_i = vecs[i].f; flush_target_i = vecs[i].ft;
            branch_flag_i = vecs[i].b; branch_target_address_i = vecs[i].bt;
            #1;
            chk("redirect_blocks_issue", ibus.ibus_req_o, 0);
            tick();
            flush_i = 1'b0; branch_flag_i = 1'b0;
            chk("misalign_pulse", misalign_o, vecs[i].exp_mis);
            exp_fetch_q.push_back(vecs[i].exp_addr);
            exp_fetch_q.push_back(vecs[i].exp_addr + 32'd4);
            tick();
            chk("misalign_one_cycle", misalign_o, 0);
            repeat (3) tick();
        end

        // Held instruction under stall, then invalidated by a branch.
        do_reset();
        stall = 6'h01;
        exp_fetch_q.push_back(32'h0);
        tick();
        tick();
        #1;
        chk("hold_no_req", ibus.ibus_req_o, 0);
        chk("hold_stallreq", stallreq, 0);
        tick();
        chk("hold_valid", inst_valid_o, 1);
        branch_flag_i = 1'b1; branch_target_address_i = 32'h20;
        tick();
        branch_flag_i = 1'b0;
        chk("branch_kills_held", inst_valid_o, 0);
        exp_fetch_q.push_back(32'h20);
        tick();
        stall = 6'h00;

        // Asynchronous reset in the middle of a fetch.
        do_reset();
        exp_fetch_q.push_back(32'h0);
        exp_fetch_q.push_back(32'h4);
        tick();
        tick();
        tick();
        lat = 5;
        tick();
        #2;
        rst = 1'b1;
        #1;
        chk_reset_outs("async_reset");
        clear_sb();
        @(posedge clk); #1;
        rst = 1'b0;
        exp_fetch_q.push_back(32'h0);
        tick();
        tick();
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
